// File: rtl/apb_slv_pkg.sv
// rtl/apb_slv_pkg.sv - shared types, register offsets and helpers for apb_slave_regbank
package apb_slv_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic [7:0]  OFS_ID           = 8'h00;
    localparam logic [7:0]  OFS_STATUS       = 8'h04;
    localparam logic [7:0]  OFS_RW0          = 8'h08;
    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// rtl/apb_slv_wait_ctr.sv - loadable 4-bit wait counter with done flag
module apb_slv_wait_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       en,
    input  logic [3:0] target,
    output logic       done
);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= 4'd0;
        end else if (load) begin
            count <= load_val;
        end else if (en) begin
            count <= count + 4'd1;
        end
    end

    // High when the increment happening this cycle reaches the target.
    assign done = ((count + 4'd1) == target);

endmodule

// File: rtl/apb_slave_regbank.sv
// rtl/apb_slave_regbank.sv - APB responder with ID, STATUS and RW scratch registers; pslverr under APB_SLV_PSLVERR_EN
module apb_slave_regbank
    import apb_slv_pkg::*;
#(
    parameter int          ADDR_W      = 32,
    parameter int          NUM_RW      = 8,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic              hclk,
    input  logic              hreset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr
);

    localparam logic [3:0] WAIT_TGT   = 4'(WAIT_STATES);
    localparam logic [6:0] MAP_WORDS  = 7'(NUM_RW + 2);
    localparam logic [5:0] IDX_ID     = OFS_ID[7:2];
    localparam logic [5:0] IDX_STATUS = OFS_STATUS[7:2];
    localparam logic [5:0] IDX_RW0    = OFS_RW0[7:2];

    state_t      state, state_nxt;
    logic        pready_q, pready_nxt;
    logic        setup, complete, commit;
    logic        ctr_load, ctr_en, ctr_done;
    logic [7:0]  addr_q;
    logic        write_q;
    logic [31:0] wdata_q;
    logic [31:0] rw_q [NUM_RW];
    logic [15:0] done_cnt;
    logic [31:0] status_word, rd_word;
    logic [5:0]  idx;
    logic        err;

    if (ADDR_W > 8) begin : g_hi
        logic unused_paddr_hi;
        assign unused_paddr_hi = ^paddr[ADDR_W-1:8];
    end

    apb_slv_wait_ctr u_wait_ctr (
        .clk      (hclk),
        .rst      (hreset),
        .load     (ctr_load),
        .load_val (4'd0),
        .en       (ctr_en),
        .target   (WAIT_TGT),
        .done     (ctr_done)
    );

    // pready is registered, so it is decided one cycle ahead of the cycle it is seen in.
    always_comb begin
        state_nxt  = state;
        pready_nxt = 1'b0;
        setup      = 1'b0;
        ctr_load   = 1'b0;
        ctr_en     = 1'b0;
        case (state)
            IDLE: begin
                if (psel && !penable) begin
                    state_nxt  = ACCESS;
                    setup      = 1'b1;
                    ctr_load   = 1'b1;
                    pready_nxt = (WAIT_STATES == 0);
                end
            end
            ACCESS: begin
                if (!psel || pready_q) begin
                    state_nxt = IDLE;
                end else if (penable) begin
                    ctr_en     = 1'b1;
                    pready_nxt = ctr_done;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign complete = (state == ACCESS) && psel && penable && pready_q;
    assign idx      = addr_q[7:2];
    assign err      = (addr_q[1:0] != 2'b00) || ({1'b0, idx} >= MAP_WORDS) ||
                      (write_q && ((idx == IDX_ID) || (idx == IDX_STATUS)));
    assign commit   = complete && write_q && !err;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state    <= IDLE;
            pready_q <= 1'b0;
            addr_q   <= 8'h00;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            done_cnt <= 16'h0;
        end else begin
            state    <= state_nxt;
            pready_q <= pready_nxt;
            if (setup) begin
                addr_q  <= paddr[7:0];
                write_q <= pwrite;
                wdata_q <= pwdata;
            end
            if (complete) begin
                done_cnt <= sat_inc16(done_cnt);
            end
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            for (int i = 0; i < NUM_RW; i++) rw_q[i] <= 32'h0;
        end else if (commit) begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (idx == 6'(i) + IDX_RW0) rw_q[i] <= wdata_q;
            end
        end
    end

`ifdef APB_SLV_PSLVERR_EN
    logic [15:0] err_cnt;

    always_ff @(posedge hclk) begin
        if (hreset) begin
            err_cnt <= 16'h0;
        end else if (complete && err) begin
            err_cnt <= sat_inc16(err_cnt);
        end
    end

    assign status_word = {err_cnt, done_cnt};
    assign pslverr     = pready_q && err;
`else
    assign status_word = {16'h0000, done_cnt};
    assign pslverr     = 1'b0;
`endif

    always_comb begin
        rd_word = 32'h0;
        if (idx == IDX_ID) begin
            rd_word = ID_VALUE;
        end else if (idx == IDX_STATUS) begin
            rd_word = status_word;
        end else begin
            for (int i = 0; i < NUM_RW; i++) begin
                if (idx == 6'(i) + IDX_RW0) rd_word = rw_q[i];
            end
        end
    end

    // STATUS is read before the completion edge increments it.
    assign prdata = (pready_q && !write_q && !err) ? rd_word : 32'h0;
    assign pready = pready_q;

endmodule

// File: tb/tb_apb_slave_regbank.sv
// tb/tb_apb_slave_regbank.sv - directed bench for apb_slave_regbank, zero-wait and 3-wait instances
module tb_apb_slave_regbank;
    import apb_slv_pkg::*;

`ifdef APB_SLV_PSLVERR_EN
    localparam logic ERR_EN = 1'b1;
`else
    localparam logic ERR_EN = 1'b0;
`endif
    localparam logic [31:0] ID = 32'hA5B0_0001;

    logic        hclk = 1'b0;
    logic        hreset;
    logic [1:0]  psel;
    logic        penable, pwrite;
    logic [31:0] paddr, pwdata;
    logic [31:0] prdata0, prdata3;
    logic        pready0, pready3, pslverr0, pslverr3;
    int          n_pass = 0;
    int          n_total = 0;

    always #5 hclk = ~hclk;

    apb_slave_regbank #(.WAIT_STATES(0)) u_ws0 (
        .hclk(hclk), .hreset(hreset), .psel(psel[0]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata0), .pready(pready0), .pslverr(pslverr0)
    );

    apb_slave_regbank #(.WAIT_STATES(3)) u_ws3 (
        .hclk(hclk), .hreset(hreset), .psel(psel[1]), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata3), .pready(pready3), .pslverr(pslverr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic cur_ready(input int s);
        return (s == 0) ? pready0 : pready3;
    endfunction

    task automatic xfer(input int s, input logic wr, input logic [7:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic er, output int waits);
        @(negedge hclk);
        psel    = (s == 0) ? 2'b01 : 2'b10;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = 32'h4000_0000 | {24'h0, a};
        pwdata  = wd;
        @(negedge hclk);
        penable = 1'b1;
        waits   = 0;
        #1;
        while (!cur_ready(s) && waits < 40) begin
            @(negedge hclk);
            #1;
            waits++;
        end
        check("pready_seen", {31'h0, cur_ready(s)}, 32'h1);
        rd = (s == 0) ? prdata0 : prdata3;
        er = (s == 0) ? pslverr0 : pslverr3;
    endtask

    task automatic wr_chk(input string tag, input int s, input logic [7:0] a, input logic [31:0] wd,
                          input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(s, 1'b1, a, wd, rd, er, w);
        check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
        check({tag, "_waits"}, w, exp_waits);
        check({tag, "_prdata0"}, rd, 32'h0);
    endtask

    task automatic rd_chk(input string tag, input int s, input logic [7:0] a, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_waits);
        logic [31:0] rd;
        logic        er;
        int          w;
        xfer(s, 1'b0, a, 32'h0, rd, er, w);
        check({tag, "_data"}, rd, exp_data);
        check({tag, "_err"}, {31'h0, er}, {31'h0, exp_err});
        check({tag, "_waits"}, w, exp_waits);
    endtask

    task automatic idle();
        @(negedge hclk);
        psel    = 2'b00;
        penable = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge hclk);
        hreset = 1'b1;
        @(negedge hclk);
        hreset = 1'b0;
    endtask

    initial begin
        psel = 2'b00; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0; pwdata = 32'h0;
        hreset = 1'b1;
        repeat (3) @(negedge hclk);
        #1;
        check("rst_pready0", {31'h0, pready0}, 32'h0);
        check("rst_prdata0", prdata0, 32'h0);
        check("rst_pslverr0", {31'h0, pslverr0}, 32'h0);
        check("rst_pready3", {31'h0, pready3}, 32'h0);
        check("rst_prdata3", prdata3, 32'h0);
        hreset = 1'b0;

        // Reset lands on the completion cycle of a write to RW[0].
        @(negedge hclk);
        psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4000_0008; pwdata = 32'hCAFE_F00D;
        @(negedge hclk);
        penable = 1'b1;
        #1;
        check("midwr_pready_pre", {31'h0, pready0}, 32'h1);
        hreset = 1'b1;
        repeat (2) @(negedge hclk);
        #1;
        check("midwr_pready", {31'h0, pready0}, 32'h0);
        check("midwr_prdata", prdata0, 32'h0);
        check("midwr_pslverr", {31'h0, pslverr0}, 32'h0);
        hreset = 1'b0; psel = 2'b00; penable = 1'b0;
        rd_chk("midwr_rw0", 0, 8'h08, 32'h0, 1'b0, 0);
        idle();

        do_reset();
        wr_chk("ws0_wr", 0, 8'h08, 32'hDEAD_BEEF, 1'b0, 0);
        rd_chk("ws0_status", 0, 8'h04, 32'h0000_0001, 1'b0, 0);
        rd_chk("ws0_rd", 0, 8'h08, 32'hDEAD_BEEF, 1'b0, 0);
        idle();

        rd_chk("ws3_id", 1, 8'h00, ID, 1'b0, 3);
        wr_chk("ws3_wr", 1, 8'h10, 32'h0000_55AA, 1'b0, 3);
        rd_chk("ws3_rd", 1, 8'h10, 32'h0000_55AA, 1'b0, 3);
        idle();

        // Three completed transfers so far on the zero-wait instance.
        wr_chk("err_wr_id", 0, 8'h00, 32'hFFFF_FFFF, ERR_EN, 0);
        wr_chk("err_wr_mis", 0, 8'h0A, 32'h0000_1111, ERR_EN, 0);
        rd_chk("err_rd_far", 0, 8'hFC, 32'h0, ERR_EN, 0);
        rd_chk("err_id_kept", 0, 8'h00, ID, 1'b0, 0);
        rd_chk("err_rw0_kept", 0, 8'h08, 32'hDEAD_BEEF, 1'b0, 0);
        rd_chk("err_status", 0, 8'h04, {(ERR_EN ? 16'd3 : 16'd0), 16'd8}, 1'b0, 0);
        idle();

        do_reset();
        for (int i = 0; i < 8; i++)
            wr_chk("b2b_wr", 0, 8'(8 + 4 * i), 32'h0101_0101 * (i + 1), 1'b0, 0);
        for (int i = 0; i < 8; i++)
            rd_chk("b2b_rd", 0, 8'(8 + 4 * i), 32'h0101_0101 * (i + 1), 1'b0, 0);
        rd_chk("b2b_status", 0, 8'h04, 32'h0000_0010, 1'b0, 0);
        idle();

        // Setup of a write to RW[1], then psel drops before completion.
        @(negedge hclk);
        psel = 2'b01; penable = 1'b0; pwrite = 1'b1; paddr = 32'h4000_000C; pwdata = 32'h0000_1234;
        @(negedge hclk);
        psel = 2'b00;
        repeat (2) @(negedge hclk);
        #1;
        check("abort_state", {31'h0, u_ws0.state}, {31'h0, IDLE});
        check("abort_pready", {31'h0, pready0}, 32'h0);
        rd_chk("abort_rw1", 0, 8'h0C, 32'h0202_0202, 1'b0, 0);
        rd_chk("abort_status", 0, 8'h04, 32'h0000_0012, 1'b0, 0);
        idle();

        repeat (2) @(negedge hclk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
